// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Brief    : Operation encoding and sizing helper for the pipelined shifter.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    typedef enum logic [2:0] {
        SH_LSL = 3'd0,
        SH_LSR = 3'd1,
        SH_ROL = 3'd2,
        SH_ROR = 3'd3,
        SH_ASR = 3'd4
    } shift_op_t;

    function automatic int shw_of(input int width);
        return $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shift_stage
//  Brief    : One registered conditional shift/rotate by 2**STAGE.
//             Carry tracking exists only when SHIFT_FLAGS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int STAGE = 0,
    localparam int SHW  = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_sign,
`ifdef SHIFT_FLAGS_EN
    input  logic             in_carry,
    output logic             out_carry,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output logic [2:0]       out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sign
);

    localparam int C_SH = 2 ** STAGE;

    logic [WIDTH-1:0] w_nxt_data;
    logic [WIDTH-1:0] w_sign_fill;

    assign w_sign_fill = {WIDTH{in_sign}} & ~({WIDTH{1'b1}} >> C_SH);

    always_comb begin
        w_nxt_data = in_data;
        if (in_shamt[STAGE]) begin
            case (in_op)
                SH_LSL:  w_nxt_data = in_data << C_SH;
                SH_LSR:  w_nxt_data = in_data >> C_SH;
                SH_ROL:  w_nxt_data = (in_data << C_SH) | (in_data >> (WIDTH - C_SH));
                SH_ROR:  w_nxt_data = (in_data >> C_SH) | (in_data << (WIDTH - C_SH));
                SH_ASR:  w_nxt_data = (in_data >> C_SH) | w_sign_fill;
                default: w_nxt_data = in_data;
            endcase
        end
    end

`ifdef SHIFT_FLAGS_EN
    // The last stage that actually moves data decides the final carry.
    logic w_nxt_carry;

    always_comb begin
        w_nxt_carry = in_carry;
        if (in_shamt[STAGE]) begin
            case (in_op)
                SH_LSL, SH_ROL:         w_nxt_carry = in_data[WIDTH-C_SH];
                SH_LSR, SH_ROR, SH_ASR: w_nxt_carry = in_data[C_SH-1];
                default:                w_nxt_carry = in_carry;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_carry <= 1'b0;
        end else if (en) begin
            out_carry <= w_nxt_carry;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_op    <= '0;
            out_tag   <= '0;
            out_sign  <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= w_nxt_data;
            out_shamt <= in_shamt;
            out_op    <= in_op;
            out_tag   <= in_tag;
            out_sign  <= in_sign;
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : shift_unit_pipe
//  Brief    : WIDTH-bit pipelined barrel shifter/rotator, one stage per shamt
//             bit, valid/ready on both sides. Optional flags: SHIFT_FLAGS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHW  = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef SHIFT_FLAGS_EN
    output logic             out_zero,
    output logic             out_carry,
`endif
    output logic [TAG_W-1:0] out_tag
);

    // Index 0 is the pipe input; index k+1 is the output of stage k.
    logic             w_valid [SHW+1];
    logic [WIDTH-1:0] w_data  [SHW+1];
    logic [SHW-1:0]   w_shamt [SHW+1];
    logic [2:0]       w_op    [SHW+1];
    logic [TAG_W-1:0] w_tag   [SHW+1];
    logic             w_sign  [SHW+1];
`ifdef SHIFT_FLAGS_EN
    logic             w_carry [SHW+1];
`endif

    logic w_stall;
    logic unused_tail;

    // The whole pipe advances or holds together, so bubbles never collapse.
    assign w_stall  = w_valid[SHW] & ~out_ready;
    assign in_ready = ~w_stall;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_shamt[0] = in_shamt;
    assign w_op[0]    = in_op;
    assign w_tag[0]   = in_tag;
    assign w_sign[0]  = in_data[WIDTH-1];
`ifdef SHIFT_FLAGS_EN
    assign w_carry[0] = 1'b0;
`endif

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .TAG_W (TAG_W),
                .STAGE (k)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (~w_stall),
                .in_valid  (w_valid[k]),
                .in_data   (w_data[k]),
                .in_shamt  (w_shamt[k]),
                .in_op     (w_op[k]),
                .in_tag    (w_tag[k]),
                .in_sign   (w_sign[k]),
`ifdef SHIFT_FLAGS_EN
                .in_carry  (w_carry[k]),
                .out_carry (w_carry[k+1]),
`endif
                .out_valid (w_valid[k+1]),
                .out_data  (w_data[k+1]),
                .out_shamt (w_shamt[k+1]),
                .out_op    (w_op[k+1]),
                .out_tag   (w_tag[k+1]),
                .out_sign  (w_sign[k+1])
            );
        end
    endgenerate

    assign out_valid = w_valid[SHW];
    assign out_data  = w_data[SHW];
    assign out_tag   = w_tag[SHW];

`ifdef SHIFT_FLAGS_EN
    // Qualified by valid so the flag reads 0 in the cleared post-reset state.
    assign out_zero  = w_valid[SHW] & (w_data[SHW] == '0);
    assign out_carry = w_carry[SHW];
`endif

    assign unused_tail = ^{w_shamt[SHW], w_op[SHW], w_sign[SHW]};

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_shift_unit_pipe
//  Brief    : Directed scoreboard bench for shift_unit_pipe (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_unit_pipe;

    localparam int W   = 32;
    localparam int TW  = 4;
    localparam int SHW = 5;

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic          carry;
        bit            chk_lat;
        int            acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [SHW-1:0] in_shamt;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
`ifdef SHIFT_FLAGS_EN
    logic          out_zero;
    logic          out_carry;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t sb[$];

    shift_unit_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SHIFT_FLAGS_EN
        .out_zero  (out_zero),
        .out_carry (out_carry),
`endif
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] d, input int n, input logic [2:0] op,
                                   input logic [TW-1:0] tg, input bit lat);
        exp_t e;
        logic [W-1:0] r;
        logic c;
        r = d;
        c = 1'b0;
        case (op)
            3'd0: begin r = d << n; if (n != 0) c = d[W-n]; end
            3'd1: begin r = d >> n; if (n != 0) c = d[n-1]; end
            3'd2: begin if (n != 0) r = (d << n) | (d >> (W-n)); if (n != 0) c = r[0]; end
            3'd3: begin if (n != 0) r = (d >> n) | (d << (W-n)); if (n != 0) c = r[W-1]; end
            3'd4: begin r = $unsigned($signed(d) >>> n); if (n != 0) c = d[n-1]; end
            default: begin r = d; c = 1'b0; end
        endcase
        e.data = r; e.tag = tg; e.carry = c; e.chk_lat = lat; e.acc_cyc = 0;
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [W-1:0] d, input int n, input logic [2:0] op,
                        input logic [TW-1:0] tg, input bit lat);
        exp_t e;
        bit   done;
        e = model(d, n, op, tg, lat);
        in_valid = 1'b1; in_data = d; in_shamt = n[SHW-1:0]; in_op = op; in_tag = tg;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                e.acc_cyc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("send_accept", {63'd0, done}, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Output monitor: pops the scoreboard on each output transfer.
    bit            prev_stall = 1'b0;
    logic [W-1:0]  prev_data;
    logic [TW-1:0] prev_tag;
    always @(negedge clk) begin
        exp_t e;
        if (prev_stall) begin
            check("stall_hold_valid", out_valid, 1'b1);
            check("stall_hold_data", out_data, prev_data);
            check("stall_hold_tag", out_tag, prev_tag);
        end
        if (out_valid === 1'b1 && out_ready === 1'b0)
            check("stall_in_ready", in_ready, 1'b0);
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", out_tag, e.tag);
`ifdef SHIFT_FLAGS_EN
                check("out_carry", out_carry, e.carry);
                check("out_zero", out_zero, (e.data == '0));
`endif
                if (e.chk_lat) check("latency", cyc - e.acc_cyc, SHW);
            end
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_data  = out_data;
        prev_tag   = out_tag;
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0;
        in_tag = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1'b1);
`ifdef SHIFT_FLAGS_EN
        check("rst_out_zero", out_zero, 1'b0);
        check("rst_out_carry", out_carry, 1'b0);
`endif
        @(posedge clk); #1;

        send(32'h0000_0001, 4, 3'd0, 4'h1, 1'b1);
        drain();

        for (int op = 0; op < 5; op++) send(32'h0000_8421, 5, op[2:0], op[3:0], 1'b0);
        for (int op = 0; op < 5; op++) send(32'h8421_8421, 5, op[2:0], op[3:0], 1'b0);
        drain();

        send(32'hFFFF_FFFF, 31, 3'd0, 4'h2, 1'b0);
        send(32'h0000_0001, 1,  3'd1, 4'h3, 1'b0);
        send(32'h8000_0000, 31, 3'd4, 4'h4, 1'b0);
        send(32'h8000_0001, 31, 3'd2, 4'h5, 1'b0);
        send(32'h8000_0001, 31, 3'd3, 4'h6, 1'b0);
        for (int op = 0; op < 8; op++) send(32'hDEAD_BEEF, 0, op[2:0], op[3:0], 1'b0);
        for (int op = 5; op < 8; op++) send(32'h1234_5678, 7, op[2:0], 4'h9, 1'b0);
        for (int i = 0; i < 10; i++)
            send($urandom, $urandom_range(0, 31), 3'($urandom_range(0, 4)), 4'(i), 1'b0);
        drain();

        fork
            for (int t = 0; t < 8; t++) send(32'hA5C3_0F01 + t, t + 1, 3'(t % 5), 4'(t), 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        send(32'h0F0F_0F0F, 3, 3'd0, 4'hA, 1'b0);
        send(32'h0F0F_0F0F, 3, 3'd1, 4'hB, 1'b0);
        send(32'h0F0F_0F0F, 3, 3'd2, 4'hC, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < SHW + 4; i++) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 1'b0);
        end
        @(posedge clk); #1;

        send(32'h0000_00F0, 4, 3'd1, 4'hD, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
